// File: rtl/rw_ram_pkg.sv
// rw_ram_pkg
//   Shared definitions for the rw_ram_sequencer block.
//   - mode_e      : operation codes presented on the mode input
//   - state_e     : sequencer FSM state encoding
//   - decode_mode : maps the raw 2-bit mode input onto mode_e (code 3 runs as COPY)
package rw_ram_pkg;

  typedef enum logic [1:0] {
    MODE_COPY = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_FILL = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The unused code 3 is folded onto COPY here so the datapath only ever
  // sees the three legal operations.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_ADD;
      2'd2:    return MODE_FILL;
      default: return MODE_COPY;
    endcase
  endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram
//   Single-port synchronous RAM, WIDTH x DEPTH, read-first.
//   Ports:
//     clk   in  clock
//     we    in  write enable
//     addr  in  word address (clog2(DEPTH) bits)
//     wdata in  write data
//     rdata out registered read data for the address presented one cycle earlier
module sp_ram #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; contents must
  // survive a reset pulse, and a reset would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rw_ram_sequencer.sv
// rw_ram_sequencer
//   Single-port RAM with a built-in block sequencer. A start pulse accepted
//   in IDLE walks len words, writing dst_base+i with a copy of src_base+i,
//   src_base+i plus operand, or operand itself. While idle, a host port
//   writes and reads the RAM.
//   Ports:
//     clk, rst            clock; asynchronous active-low reset
//     start, ready, done  launch handshake (start sampled only while ready=1)
//     mode                0 COPY, 1 ADD, 2 FILL, 3 acts as COPY
//     src_base, dst_base  first source / destination word address
//     len                 word count 0..DEPTH
//     operand             addend (ADD) or fill value (FILL)
//     host_we, host_addr, host_wdata  host write port (idle only)
//     host_rdata          host read data, one-cycle latency, frozen while busy
module rw_ram_sequencer #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    src_base,
  input  logic [AW-1:0]    dst_base,
  input  logic [AW:0]      len,
  input  logic [WIDTH-1:0] operand,
  output logic             ready,
  output logic             done,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata
);

  import rw_ram_pkg::*;

  localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

  state_e           state_q;
  mode_e            mode_q;
  logic [AW-1:0]    src_q;
  logic [AW-1:0]    dst_q;
  logic [AW:0]      len_q;
  logic [AW:0]      idx_q;
  logic [AW:0]      idx_d;
  logic [WIDTH-1:0] operand_q;
  logic             ready_q;
  logic             done_q;
  logic             host_valid_q;
  logic [WIDTH-1:0] host_hold_q;
  logic             last_word;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] seq_wdata;

  sp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Word index is AW+1 bits so len=DEPTH terminates; only the low AW bits
  // feed the address adders, which therefore wrap modulo DEPTH.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    idx_d     = idx_q + IDX_ONE;
    last_word = (idx_d == len_q);

    case (mode_q)
      MODE_ADD:  seq_wdata = ram_rdata + operand_q;
      MODE_FILL: seq_wdata = operand_q;
      default:   seq_wdata = ram_rdata;
    endcase

    // Host owns the RAM in IDLE; the sequencer owns it otherwise, which is
    // also what drops host writes while busy.
    ram_we    = 1'b0;
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    case (state_q)
      ST_IDLE:  ram_we = host_we;
      ST_READ:  ram_addr = src_q + idx_q[AW-1:0];
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = dst_q + idx_q[AW-1:0];
        ram_wdata = seq_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register in the block sees the pre-edge value of every other one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      operand_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= decode_mode(mode);
            src_q     <= src_base;
            dst_q     <= dst_base;
            len_q     <= len;
            operand_q <= operand;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (decode_mode(mode) == MODE_FILL) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: state_q <= ST_WRITE;
        ST_WRITE: begin
          idx_q <= idx_d;
          if (last_word) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (mode_q == MODE_FILL) begin
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_READ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The RAM read register reflects host_addr only after an edge taken in
  // IDLE. Past that, the last host-visible word is held so host_rdata does
  // not follow sequencer traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_valid_q <= 1'b0;
      host_hold_q  <= '0;
    end else begin
      host_valid_q <= (state_q == ST_IDLE);
      if (host_valid_q) begin
        host_hold_q <= ram_rdata;
      end
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign host_rdata = host_valid_q ? ram_rdata : host_hold_q;

endmodule

// File: tb/tb_rw_ram_sequencer.sv
// tb_rw_ram_sequencer
//   Directed bench for rw_ram_sequencer (WIDTH=16, DEPTH=256). Inputs are
//   driven just after the falling edge; outputs are sampled 1 time unit
//   after the rising edge. Edge 0 is the rising edge that accepts start.
module tb_rw_ram_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             start      = 1'b0;
  logic [1:0]       mode       = '0;
  logic [AW-1:0]    src_base   = '0;
  logic [AW-1:0]    dst_base   = '0;
  logic [AW:0]      len        = '0;
  logic [WIDTH-1:0] operand    = '0;
  logic             host_we    = 1'b0;
  logic [AW-1:0]    host_addr  = '0;
  logic [WIDTH-1:0] host_wdata = '0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] host_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rw_ram_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .operand    (operand),
    .ready      (ready),
    .done       (done),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  task automatic host_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
    @(negedge clk);
    host_addr = a;
    @(posedge clk);
    #1 d = host_rdata;
  endtask

  // Launches one run, scrambles the operand inputs after edge 0, and watches
  // edges 0..exp_edge+1. Reports the first edge with done high, the number of
  // sampled done cycles, ready after edge 0 and ready after edge exp_edge+1.
  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] l, input logic [WIDTH-1:0] op, input int exp_edge,
                        input bit host_we_busy, output int first_done, output int done_cnt,
                        output logic rdy0, output logic rdy_end);
    @(negedge clk);
    mode = m; src_base = s; dst_base = d; len = l; operand = op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m; src_base = ~s; dst_base = ~d; len = 9'h155; operand = ~op;
    if (host_we_busy) host_we = 1'b1;
    rdy0       = ready;
    first_done = -1;
    done_cnt   = 0;
    for (int k = 0; k <= exp_edge + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        if (first_done < 0) first_done = k;
        done_cnt++;
      end
    end
    rdy_end = ready;
    host_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (host_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_host_rdata: got %h expected 0000", host_rdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_copy();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    for (int i = 0; i < 8; i++) host_write(AW'(i), WIDTH'(16'h10 + i));
    run_op(2'd0, 8'd0, 8'd32, 9'd8, 16'h0000, 16, 1'b0, fd, dc, r0, r1);
    vectors++; if (r0 !== 1'b0) begin miscompares++; $display("FAIL copy_ready_busy: got %b expected 0", r0); end
    vectors++; if (fd !== 16) begin miscompares++; $display("FAIL copy_done_edge: got %0d expected 16", fd); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL copy_done_cycles: got %0d expected 1", dc); end
    vectors++; if (r1 !== 1'b1) begin miscompares++; $display("FAIL copy_ready_after: got %b expected 1", r1); end
    for (int i = 0; i < 8; i++) begin
      host_read(AW'(32 + i), got);
      vectors++; if (got !== WIDTH'(16'h10 + i)) begin miscompares++; $display("FAIL copy_word_%0d: got %h expected %h", 32 + i, got, WIDTH'(16'h10 + i)); end
    end
  endtask

  task automatic test_add();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] exp_w [5] = '{16'h000F, 16'h0010, 16'h0011, 16'h0012, 16'h0014};
    run_op(2'd1, 8'd0, 8'd0, 9'd4, 16'hFFFF, 8, 1'b0, fd, dc, r0, r1);
    vectors++; if (fd !== 8) begin miscompares++; $display("FAIL add_done_edge: got %0d expected 8", fd); end
    vectors++; if (dc !== 1 || r1 !== 1'b1) begin miscompares++; $display("FAIL add_handshake: got cycles=%0d ready=%b expected cycles=1 ready=1", dc, r1); end
    for (int i = 0; i < 5; i++) begin
      host_read(AW'(i), got);
      vectors++; if (got !== exp_w[i]) begin miscompares++; $display("FAIL add_word_%0d: got %h expected %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_fill();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    run_op(2'd2, 8'd0, 8'd250, 9'd10, 16'hA5A5, 10, 1'b0, fd, dc, r0, r1);
    vectors++; if (fd !== 10) begin miscompares++; $display("FAIL fill_done_edge: got %0d expected 10", fd); end
    vectors++; if (dc !== 1 || r1 !== 1'b1) begin miscompares++; $display("FAIL fill_handshake: got cycles=%0d ready=%b expected cycles=1 ready=1", dc, r1); end
    for (int i = 0; i < 10; i++) begin
      host_read(AW'(250 + i), got);
      vectors++; if (got !== 16'hA5A5) begin miscompares++; $display("FAIL fill_word_%0d: got %h expected a5a5", (250 + i) % DEPTH, got); end
    end
    host_read(8'd4, got);
    vectors++; if (got !== 16'h0014) begin miscompares++; $display("FAIL fill_word_4_kept: got %h expected 0014", got); end
  endtask

  task automatic test_len_zero();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    host_write(8'd100, 16'h1234);
    for (int m = 0; m < 4; m++) begin
      run_op(2'(m), 8'd32, 8'd100, 9'd0, 16'h7777, 0, 1'b0, fd, dc, r0, r1);
      vectors++; if (fd !== 0 || dc !== 1) begin miscompares++; $display("FAIL len0_mode%0d_done: got edge=%0d cycles=%0d expected edge=0 cycles=1", m, fd, dc); end
      vectors++; if (r0 !== 1'b0 || r1 !== 1'b1) begin miscompares++; $display("FAIL len0_mode%0d_ready: got %b/%b expected 0/1", m, r0, r1); end
    end
    host_read(8'd100, got);
    vectors++; if (got !== 16'h1234) begin miscompares++; $display("FAIL len0_no_write: got %h expected 1234", got); end
  endtask

  task automatic test_host_we_busy();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    host_write(8'd200, 16'h0BAD);
    host_addr  = 8'd200;
    host_wdata = 16'hDEAD;
    run_op(2'd0, 8'd32, 8'd40, 9'd2, 16'h0000, 4, 1'b1, fd, dc, r0, r1);
    vectors++; if (fd !== 4) begin miscompares++; $display("FAIL busy_done_edge: got %0d expected 4", fd); end
    host_read(8'd200, got);
    vectors++; if (got !== 16'h0BAD) begin miscompares++; $display("FAIL busy_host_write_dropped: got %h expected 0bad", got); end
    host_read(8'd40, got);
    vectors++; if (got !== 16'h0010) begin miscompares++; $display("FAIL busy_copy_word_40: got %h expected 0010", got); end
    host_read(8'd41, got);
    vectors++; if (got !== 16'h0011) begin miscompares++; $display("FAIL busy_copy_word_41: got %h expected 0011", got); end
  endtask

  task automatic test_back_to_back();
    logic done_at [12];
    logic ready_at [12];
    int n_done;
    logic [WIDTH-1:0] got;
    @(negedge clk);
    mode = 2'd0; src_base = 8'd0; dst_base = 8'd64; len = 9'd2; operand = '0; start = 1'b1;
    @(posedge clk);
    #1;
    n_done = 0;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk);
      #1;
      done_at[k]  = done;
      ready_at[k] = ready;
      if (done === 1'b1) n_done++;
      if (k == 6) start = 1'b0;
    end
    vectors++; if (done_at[4] !== 1'b1 || done_at[10] !== 1'b1) begin miscompares++; $display("FAIL b2b_done_edges: got e4=%b e10=%b expected 1/1", done_at[4], done_at[10]); end
    vectors++; if (n_done !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    vectors++; if (ready_at[5] !== 1'b1 || ready_at[6] !== 1'b0) begin miscompares++; $display("FAIL b2b_restart: got ready e5=%b e6=%b expected 1/0", ready_at[5], ready_at[6]); end
    vectors++; if (ready_at[11] !== 1'b1) begin miscompares++; $display("FAIL b2b_final_ready: got %b expected 1", ready_at[11]); end
    host_read(8'd65, got);
    vectors++; if (got !== 16'hA5A5) begin miscompares++; $display("FAIL b2b_word_65: got %h expected a5a5", got); end
  endtask

  task automatic test_reset_mid_run();
    int fd, dc, n_done; logic r0, r1; logic [WIDTH-1:0] got;
    for (int i = 0; i < 8; i++) host_write(AW'(i), WIDTH'(16'h20 + i));
    @(negedge clk);
    mode = 2'd0; src_base = 8'd0; dst_base = 8'd48; len = 9'd8; operand = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL abort_immediate: got ready=%b done=%b expected 1/0", ready, done); end
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || ready !== 1'b1) n_done++;
    end
    vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", n_done); end
    run_op(2'd0, 8'd0, 8'd48, 9'd8, 16'h0000, 16, 1'b0, fd, dc, r0, r1);
    vectors++; if (fd !== 16 || dc !== 1) begin miscompares++; $display("FAIL abort_rerun_done: got edge=%0d cycles=%0d expected 16/1", fd, dc); end
    for (int i = 0; i < 8; i++) begin
      host_read(AW'(48 + i), got);
      vectors++; if (got !== WIDTH'(16'h20 + i)) begin miscompares++; $display("FAIL abort_rerun_word_%0d: got %h expected %h", 48 + i, got, WIDTH'(16'h20 + i)); end
    end
  endtask

  task automatic test_overlap();
    int fd, dc; logic r0, r1; logic [WIDTH-1:0] got;
    for (int i = 0; i < 5; i++) host_write(AW'(i), WIDTH'(i + 1));
    run_op(2'd0, 8'd0, 8'd1, 9'd4, 16'h0000, 8, 1'b0, fd, dc, r0, r1);
    vectors++; if (fd !== 8) begin miscompares++; $display("FAIL overlap_done_edge: got %0d expected 8", fd); end
    for (int i = 0; i < 5; i++) begin
      host_read(AW'(i), got);
      vectors++; if (got !== 16'h0001) begin miscompares++; $display("FAIL overlap_word_%0d: got %h expected 0001", i, got); end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_add();
    test_fill();
    test_len_zero();
    test_host_we_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
